tmc_spi_master: RTL and testbench

SPI master engine for the TMC5130 datagram link, directly downstream of the TMCSPI AXI-lite register slave. Accepts one 40-bit datagram (8-bit address incl. write flag, 32-bit data) per handshake. Shifts it out in SPI mode 3, MSB first, while capturing the 40-bit reply (8-bit status, 32-bit data). Returns the reply to the register slave.

---
 rtl/tmc_spi_pkg.sv | 32 +++
 rtl/tmc_spi_sync2.sv | 23 ++
 rtl/tmc_spi_master.sv | 154 +++++++++++++++
 tb/tb_tmc_spi_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmc_spi_pkg.sv
// Shared constants and FSM state type for the TMC5130 SPI datagram engine.
package tmc_spi_pkg;

    localparam int FRAME_BITS  = 40;
    localparam int STATUS_BITS = 8;
    localparam int DATA_BITS   = 32;

    // Datagram layout: address byte on top, write flag is its MSB.
    localparam int ADDR_MSB    = 39;
    localparam int ADDR_LSB    = 32;
    localparam int WR_FLAG_BIT = 39;
    localparam int DATA_MSB    = 31;
    localparam int DATA_LSB    = 0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tmc_spi_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module tmc_spi_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/tmc_spi_master.sv
// SPI mode-3 master moving one 40-bit TMC5130 datagram per request.
// States: IDLE wait request | SETUP CSN lead-in | SHIFT 40 bits | HOLD CSN tail | GAP CSN-high spacing.
module tmc_spi_master
    import tmc_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [FRAME_BITS-1:0]  req_data,
    output logic                   rsp_valid,
    output logic [STATUS_BITS-1:0] rsp_status,
    output logic [DATA_BITS-1:0]   rsp_data,
    output logic                   busy,
    output logic                   spi_csn,
    output logic                   spi_sck,
    output logic                   spi_mosi,
    input  logic                   spi_miso
);
    localparam int TW = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE) + 1);
    typedef logic [TW-1:0] tcnt_t;

    localparam tcnt_t T_ONE   = tcnt_t'(1);
    localparam tcnt_t T_DIV   = tcnt_t'(CLK_DIV - 1);
    localparam tcnt_t T_SETUP = tcnt_t'(CS_SETUP - 1);
    localparam tcnt_t T_HOLD  = tcnt_t'(CS_HOLD - 1);
    localparam tcnt_t T_IDLE  = tcnt_t'(CS_IDLE - 1);

    spi_state_t             state_q;
    tcnt_t                  tcnt_q;
    logic [5:0]             bit_q;
    logic [FRAME_BITS-2:0]  tx_q;
    logic [FRAME_BITS-1:0]  rx_q;
    logic                   ready_q;
    logic                   rsp_valid_q;
    logic                   busy_q;
    logic                   csn_q;
    logic                   sck_q;
    logic                   mosi_q;
    logic [STATUS_BITS-1:0] status_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   miso_s;

    tmc_spi_sync2 u_sync (
        .clk_i (ACLK),
        .rst_i (ARESET),
        .d_i   (spi_miso),
        .q_o   (miso_s)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= IDLE;
            tcnt_q      <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            csn_q       <= 1'b1;
            sck_q       <= 1'b1;
            mosi_q      <= 1'b0;
            status_q    <= '0;
            data_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        state_q <= SETUP;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        csn_q   <= 1'b0;
                        mosi_q  <= req_data[FRAME_BITS-1];
                        tx_q    <= req_data[FRAME_BITS-2:0];
                        tcnt_q  <= T_SETUP;
                    end
                end
                SETUP: begin
                    if (tcnt_q == '0) begin
                        state_q <= SHIFT;
                        sck_q   <= 1'b0;
                        bit_q   <= 6'(FRAME_BITS - 1);
                        tcnt_q  <= T_DIV;
                    end else begin
                        tcnt_q <= tcnt_q - T_ONE;
                    end
                end
                SHIFT: begin
                    if (tcnt_q != '0) begin
                        tcnt_q <= tcnt_q - T_ONE;
                    end else begin
                        tcnt_q <= T_DIV;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            // End of high phase: synchroniser delay keeps the sample inside the high phase.
                            rx_q <= {rx_q[FRAME_BITS-2:0], miso_s};
                            if (bit_q == '0) begin
                                state_q <= HOLD;
                                tcnt_q  <= T_HOLD;
                            end else begin
                                bit_q  <= bit_q - 6'd1;
                                sck_q  <= 1'b0;
                                mosi_q <= tx_q[FRAME_BITS-2];
                                tx_q   <= {tx_q[FRAME_BITS-3:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tcnt_q == '0) begin
                        state_q     <= GAP;
                        csn_q       <= 1'b1;
                        mosi_q      <= 1'b0;
                        status_q    <= rx_q[ADDR_MSB:ADDR_LSB];
                        data_q      <= rx_q[DATA_MSB:DATA_LSB];
                        rsp_valid_q <= 1'b1;
                        tcnt_q      <= T_IDLE;
                    end else begin
                        tcnt_q <= tcnt_q - T_ONE;
                    end
                end
                GAP: begin
                    if (tcnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q - T_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_status = status_q;
    assign rsp_data   = data_q;
    assign busy       = busy_q;
    assign spi_csn    = csn_q;
    assign spi_sck    = sck_q;
    assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_tmc_spi_master.sv
// Self-checking bench: table of datagrams against a behavioural slave, plus framing corner cases.
module tb_tmc_spi_master;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic arst;
    int   cyc = 0;
    always @(posedge aclk) cyc++;

    logic        rv0, rr0, rspv0, busy0, csn0, sck0, mosi0;
    logic        miso0 = 1'b0;
    logic [39:0] rd0;
    logic [7:0]  st0;
    logic [31:0] dt0;

    logic        rv3, rr3, rspv3, busy3, csn3, sck3, mosi3;
    logic        miso3 = 1'b0;
    logic [39:0] rd3;
    logic [7:0]  st3;
    logic [31:0] dt3;

    tmc_spi_master u_dut (
        .ACLK(aclk), .ARESET(arst), .req_valid(rv0), .req_ready(rr0), .req_data(rd0),
        .rsp_valid(rspv0), .rsp_status(st0), .rsp_data(dt0), .busy(busy0),
        .spi_csn(csn0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_miso(miso0)
    );

    tmc_spi_master #(.CLK_DIV(3)) u_dut3 (
        .ACLK(aclk), .ARESET(arst), .req_valid(rv3), .req_ready(rr3), .req_data(rd3),
        .rsp_valid(rspv3), .rsp_status(st3), .rsp_data(dt3), .busy(busy3),
        .spi_csn(csn3), .spi_sck(sck3), .spi_mosi(mosi3), .spi_miso(miso3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural TMC5130 slave: serves reply MSB first, one bit per SCK falling edge.
    logic [39:0] sl_word0 = '0, sl_word3 = '0;
    int sl_idx0 = 39, sl_idx3 = 39;
    always @(negedge sck0 or posedge csn0) begin
        if (csn0 === 1'b1) sl_idx0 = 39;
        else if (sl_idx0 >= 0) begin miso0 = sl_word0[sl_idx0]; sl_idx0--; end
    end
    always @(negedge sck3 or posedge csn3) begin
        if (csn3 === 1'b1) sl_idx3 = 39;
        else if (sl_idx3 >= 0) begin miso3 = sl_word3[sl_idx3]; sl_idx3--; end
    end

    logic [39:0] mosi_cap0 = '0;
    int rises0 = 0;
    always @(posedge sck0) if (csn0 === 1'b0) begin mosi_cap0 = {mosi_cap0[38:0], mosi0}; rises0++; end

    logic prev_csn0 = 1'b1, prev_sck0 = 1'b1, prev_rv0 = 1'b0;
    bit   half_on0 = 1'b0;
    int low_run0 = 0, last_low0 = 0, hi_run0 = 0, last_gap0 = 0, half_run0 = 0, half_bad0 = 0;
    int rsp_cnt0 = 0, rv_wide0 = 0, rv_nocsn0 = 0, csn_falls0 = 0;
    logic [7:0]  st_arr0[64];
    logic [31:0] dt_arr0[64];
    int fall_cyc0[64];
    always @(negedge aclk) begin
        if (csn0 === 1'b0) begin
            low_run0++;
            if (prev_csn0 === 1'b1) begin
                last_gap0 = hi_run0; hi_run0 = 0;
                if (csn_falls0 < 64) fall_cyc0[csn_falls0] = cyc;
                csn_falls0++;
            end
            if (sck0 !== prev_sck0) begin
                if (half_on0 && half_run0 != 4) half_bad0++;
                half_on0 = 1'b1; half_run0 = 1;
            end else half_run0++;
        end else begin
            hi_run0++;
            if (prev_csn0 === 1'b0) begin last_low0 = low_run0; low_run0 = 0; hi_run0 = 1; end
            half_on0 = 1'b0;
        end
        if (rspv0 === 1'b1) begin
            if (rsp_cnt0 < 64) begin st_arr0[rsp_cnt0] = st0; dt_arr0[rsp_cnt0] = dt0; end
            rsp_cnt0++;
            if (prev_rv0 === 1'b1) rv_wide0++;
            if (!(csn0 === 1'b1 && prev_csn0 === 1'b0)) rv_nocsn0++;
        end
        prev_csn0 = csn0; prev_sck0 = sck0; prev_rv0 = rspv0;
    end

    logic prev_csn3 = 1'b1;
    int low_run3 = 0, last_low3 = 0, rsp_cnt3 = 0;
    logic [7:0]  st_last3 = '0;
    logic [31:0] dt_last3 = '0;
    always @(negedge aclk) begin
        if (csn3 === 1'b0) low_run3++;
        else if (prev_csn3 === 1'b0) begin last_low3 = low_run3; low_run3 = 0; end
        if (rspv3 === 1'b1) begin st_last3 = st3; dt_last3 = dt3; rsp_cnt3++; end
        prev_csn3 = csn3;
    end

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic send0(input logic [39:0] d);
        int n = 0;
        while (rr0 !== 1'b1 && n < 2000) begin tick(); n++; end
        chk("accept_wait", rr0, 1'b1);
        rd0 = d; rv0 = 1'b1;
        tick();
        rv0 = 1'b0;
    endtask

    task automatic wait_rsp0(input int n);
        int k = 0;
        while (rsp_cnt0 < n && k < 2000) begin tick(); k++; end
        chk("rsp_arrived", rsp_cnt0 >= n, 1'b1);
    endtask

    typedef struct {
        logic [39:0] req;
        logic [39:0] reply;
        logic [7:0]  exp_st;
        logic [31:0] exp_dt;
    } vec_t;
    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int r0 = rises0, base = rsp_cnt0, hb = half_bad0, wb = rv_wide0, nc = rv_nocsn0;
        sl_word0 = v.reply;
        send0(v.req);
        wait_rsp0(base + 1);
        chk("mosi_stream", mosi_cap0, v.req);
        chk("sck_rises", rises0 - r0, 40);
        chk("rsp_status", st_arr0[base], v.exp_st);
        chk("rsp_data", dt_arr0[base], v.exp_dt);
        chk("csn_low_cycles", last_low0, 328);
        chk("busy_in_gap", busy0, 1'b1);
        repeat (7) tick();
        chk("ready_before_gap_end", rr0, 1'b0);
        tick();
        chk("ready_after_gap", rr0, 1'b1);
        chk("busy_idle", busy0, 1'b0);
        chk("sck_half_period", half_bad0 - hb, 0);
        chk("rsp_valid_width", rv_wide0 - wb, 0);
        chk("rsp_with_csn_rise", rv_nocsn0 - nc, 0);
    endtask

    initial begin
        int base, f, k, r0;
        vec_t v;
        arst = 1'b0; rv0 = 1'b0; rd0 = '0; rv3 = 1'b0; rd3 = '0;
        #1 arst = 1'b1;
        repeat (3) tick();
        chk("rst_csn", csn0, 1'b1);
        chk("rst_sck", sck0, 1'b1);
        chk("rst_mosi", mosi0, 1'b0);
        chk("rst_ready", rr0, 1'b0);
        chk("rst_rsp_valid", rspv0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_rsp", {st0, dt0}, 40'h0);
        arst = 1'b0;
        chk("ready_at_release", rr0, 1'b0);
        tick();
        chk("ready_cycle_after_release", rr0, 1'b1);

        vecs[0] = '{40'hA1_00001234, 40'h05_DEADBEEF, 8'h05, 32'hDEADBEEF};
        vecs[1] = '{40'hFF_FFFFFFFF, 40'h00_00000000, 8'h00, 32'h00000000};
        vecs[2] = '{40'h00_00000000, 40'hFF_FFFFFFFF, 8'hFF, 32'hFFFFFFFF};
        for (int i = 3; i < 6; i++) begin
            vecs[i].req   = {8'($urandom), 32'($urandom)};
            vecs[i].reply = {8'($urandom), 32'($urandom)};
            vecs[i].exp_st = vecs[i].reply[39:32];
            vecs[i].exp_dt = vecs[i].reply[31:0];
        end
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-to-back with req_valid held high.
        base = rsp_cnt0; f = csn_falls0;
        sl_word0 = 40'h0A_11111111;
        k = 0;
        while (rr0 !== 1'b1 && k < 2000) begin tick(); k++; end
        rd0 = 40'h81_AAAA0001; rv0 = 1'b1;
        tick();
        rd0 = 40'h02_BBBB0002;
        wait_rsp0(base + 1);
        sl_word0 = 40'h0B_22222222;
        k = 0;
        while (csn_falls0 - f < 2 && k < 2000) begin tick(); k++; end
        rv0 = 1'b0;
        chk("b2b_second_frame", csn_falls0 - f, 2);
        chk("b2b_period", fall_cyc0[f+1] - fall_cyc0[f], 337);
        chk("b2b_gap_min", last_gap0 >= 8, 1'b1);
        wait_rsp0(base + 2);
        chk("b2b_first_rsp", {st_arr0[base], dt_arr0[base]}, 40'h0A_11111111);
        chk("b2b_second_rsp", {st_arr0[base+1], dt_arr0[base+1]}, 40'h0B_22222222);
        chk("b2b_second_mosi", mosi_cap0, 40'h02_BBBB0002);

        // req_valid pulsed mid-SHIFT must be ignored.
        repeat (10) tick();
        base = rsp_cnt0; f = csn_falls0; r0 = rises0;
        sl_word0 = 40'h12_89ABCDEF;
        send0(40'h80_00000055);
        k = 0;
        while (rises0 - r0 < 10 && k < 2000) begin tick(); k++; end
        chk("shift_ready_low", rr0, 1'b0);
        rd0 = 40'hFF_FFFFFFFF; rv0 = 1'b1;
        repeat (2) tick();
        rv0 = 1'b0;
        wait_rsp0(base + 1);
        chk("ignore_rsp", {st_arr0[base], dt_arr0[base]}, 40'h12_89ABCDEF);
        chk("ignore_mosi", mosi_cap0, 40'h80_00000055);
        repeat (400) tick();
        chk("ignore_no_extra_frame", csn_falls0 - f, 1);
        chk("ignore_no_extra_rsp", rsp_cnt0 - base, 1);

        // CLK_DIV=3 instance with alternating MISO.
        sl_word3 = 40'hAA_55555555;
        k = 0;
        while (rr3 !== 1'b1 && k < 2000) begin tick(); k++; end
        rd3 = 40'h21_00000000; rv3 = 1'b1;
        tick();
        rv3 = 1'b0;
        k = 0;
        while (rsp_cnt3 < 1 && k < 2000) begin tick(); k++; end
        chk("div3_rsp_status", st_last3, 8'hAA);
        chk("div3_rsp_data", dt_last3, 32'h55555555);
        chk("div3_csn_low", last_low3, 248);

        // Reset in the middle of bit 20.
        repeat (10) tick();
        base = rsp_cnt0; r0 = rises0;
        sl_word0 = 40'h77_01234567;
        send0(40'h0F_CAFEF00D);
        k = 0;
        while (rises0 - r0 < 20 && k < 2000) begin tick(); k++; end
        chk("at_bit20", rises0 - r0, 20);
        arst = 1'b1;
        #1;
        chk("mid_rst_csn", csn0, 1'b1);
        chk("mid_rst_sck", sck0, 1'b1);
        chk("mid_rst_mosi", mosi0, 1'b0);
        chk("mid_rst_ready_busy", {rr0, busy0, rspv0}, 3'b000);
        chk("mid_rst_rsp_cleared", {st0, dt0}, 40'h0);
        repeat (3) tick();
        arst = 1'b0;
        chk("mid_rst_ready_release", rr0, 1'b0);
        tick();
        chk("mid_rst_ready_next", rr0, 1'b1);
        chk("mid_rst_no_rsp", rsp_cnt0 - base, 0);
        v = '{40'h93_12345678, 40'h3C_0F0F0F0F, 8'h3C, 32'h0F0F0F0F};
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
